multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle controller for the MIPS-subset datapath: R-format, lw, sw, beq, nandi, baln, bgezal, jsp.
//  Sequences a shared-memory datapath (IR, A/B, ALUOut, MDR) over 3-5 states per instruction.
//  Stalls on memory handshake; a watchdog halts the machine on a stuck memory.
//  Replaces per-instruction single-cycle decode.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles waiting for mem_ready before fault; 0 disables watchdog
//  CNT_W        5   watchdog counter width; must satisfy MEM_TIMEOUT < 2**CNT_W
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-high
//  opcode      in   6  IR[31:26], valid from DECODE onward
//  zero        in   1  ALU zero flag (current cycle)
//  status_n    in   1  registered ALU negative flag (for baln)
//  rs_sign     in   1  A-register bit 31 (for bgezal)
//  mem_ready   in   1  memory access completes this cycle
//  pc_write    out  1  effective PC enable; branch condition already applied
//  iord        out  2  mem addr: 00 PC, 01 ALUOut, 10 A
//  mem_read    out  1  ;  mem_write out 1 ;  ir_write out 1
//  reg_dst     out  2  00 rt, 01 rd, 10 $31
//  mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
//  reg_write   out  1
//  alu_src_a   out  1  0 PC, 1 A
//  alu_src_b   out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op      out  2  00 add, 01 sub, 10 funct, 11 nand
//  pc_source   out  2  00 ALU result, 01 ALUOut (branch target), 10 memory read data
//  illegal_op  out  1  sticky ; mem_fault out 1 sticky ; state_o out 4 current state
// BEHAVIOUR
//  Opcodes: R 000000, lw 100011, sw 101011, beq 000100, nandi 010000, baln 011011, bgezal 000001, jsp 010010.
//  Reset: state=FETCH(0), wait_cnt=0, illegal_op=mem_fault=0. All strobes are forced 0 while reset is high.
//  First FETCH is the cycle after reset release. Unlisted outputs are 0 in every state.
//  Outputs decode combinationally from state, mem_ready, zero, status_n and rs_sign.
//  0 FETCH: iord=00, mem_read, alu_src_a=0, alu_src_b=01, alu_op=00.
//     On mem_ready: ir_write=1, pc_write=1, pc_source=00 -> DECODE; else hold.
//  1 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute target).
//     Dispatch: lw/sw->2, R->6, beq->8, nandi->9, baln->11, bgezal->12, jsp->13, other->14 with illegal_op set.
//  2 MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->3, sw->5
//  3 MEMREAD: iord=01, mem_read; mem_ready->4
//  4 MEMWB: reg_dst=00, mem_to_reg=01, reg_write -> 0
//  5 MEMWRITE: iord=01, mem_write; mem_ready->0
//  6 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> 7
//  7 RWB: reg_dst=01, mem_to_reg=00, reg_write -> 0
//  8 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero -> 0
//  9 NANDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11 -> 10
//  10 NANDI_WB: reg_dst=00, mem_to_reg=00, reg_write -> 0
//  11 BALN: if status_n then pc_write, pc_source=01, reg_write, reg_dst=10, mem_to_reg=10. -> 0
//  12 BGEZAL: link always (reg_write, reg_dst=10, mem_to_reg=10); pc_write=~rs_sign, pc_source=01. -> 0
//  13 JSP: iord=10, mem_read; on mem_ready: pc_write, pc_source=10 -> 0
//  14 HALT: all strobes 0, absorbing until reset. State 15 is unreachable; if entered, go to HALT.
//  Memory states (0,3,5,13): request held stable until mem_ready.
//     Each cycle with mem_ready=0, wait_cnt increments; it clears on any state change.
//     If MEM_TIMEOUT!=0, wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: next state HALT, mem_fault=1.
//     If mem_ready rises in that same cycle, mem_ready wins.
//  Reset mid-access drops the request immediately (async) and discards the partial instruction.
// TESTING
//  Assert reset during MEMREAD -> same cycle mem_read=0, state_o=0; after release FETCH, faults 0.
//  lw, mem_ready low 3 cycles each access -> states 0x4,1,2,3x4,4,0; reg_write one cycle, mem_to_reg=01.
//  beq zero=1 -> state 8 pc_write=1 pc_source=01; rerun zero=0 -> pc_write=0.
//  baln status_n=0 -> no pc_write/reg_write; bgezal rs_sign=1 -> reg_write=1 reg_dst=10, pc_write=0.
//  jsp, mem_ready on 3rd cycle of state 13 -> iord=10 throughout, pc_write=1 pc_source=10 once, then 0.
//  FETCH with mem_ready stuck 0 -> HALT after 16 cycles, mem_fault=1 sticky; opcode 111111 -> illegal_op=1, HALT.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS-subset controller with memory-stall watchdog
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       status_n,
    input  logic       rs_sign,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BEQ      = 4'd8,
        S_NANDI_EX = 4'd9,
        S_NANDI_WB = 4'd10,
        S_BALN     = 4'd11,
        S_BGEZAL   = 4'd12,
        S_JSP      = 4'd13,
        S_HALT     = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_NANDI  = 6'b010000;
    localparam logic [5:0] OP_BALN   = 6'b011011;
    localparam logic [5:0] OP_BGEZAL = 6'b000001;
    localparam logic [5:0] OP_JSP    = 6'b010010;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state, timeout, decode_bad;

    // mem_ready has priority over the watchdog in the final waiting cycle
    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                    (state == S_MEMWRITE) || (state == S_JSP);
        timeout   = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (wait_cnt == TO_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (decode_bad)
                illegal_op <= 1'b1;
            if (timeout)
                mem_fault <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        decode_bad = 1'b0;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADDR;
                    OP_R:         state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_NANDI:     state_next = S_NANDI_EX;
                    OP_BALN:      state_next = S_BALN;
                    OP_BGEZAL:    state_next = S_BGEZAL;
                    OP_JSP:       state_next = S_JSP;
                    default: begin
                        state_next = S_HALT;
                        decode_bad = 1'b1;
                    end
                endcase
            end
            S_MEMADDR:  state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXEC:     state_next = S_RWB;
            S_RWB:      state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_NANDI_EX: state_next = S_NANDI_WB;
            S_NANDI_WB: state_next = S_FETCH;
            S_BALN:     state_next = S_FETCH;
            S_BGEZAL:   state_next = S_FETCH;
            S_JSP:      if (mem_ready) state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_HALT;
        endcase
        if (timeout)
            state_next = S_HALT;
    end

    // Gating on reset drops any in-flight memory request without waiting for a clock
    always_comb begin
        pc_write   = 1'b0;
        iord       = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE:   alu_src_b = 2'b11;
                S_MEMADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMREAD: begin
                    iord     = 2'b01;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    iord      = 2'b01;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RWB: begin
                    reg_dst   = 2'b01;
                    reg_write = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_write  = zero;
                end
                S_NANDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                end
                S_NANDI_WB: reg_write = 1'b1;
                S_BALN: begin
                    if (status_n) begin
                        pc_write   = 1'b1;
                        pc_source  = 2'b01;
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                S_BGEZAL: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    pc_write   = ~rs_sign;
                    pc_source  = 2'b01;
                end
                S_JSP: begin
                    iord     = 2'b10;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        pc_write  = 1'b1;
                        pc_source = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] psrc;
        logic       ill;
        logic       mf;
    } ov_t;

    typedef struct {
        ov_t   v;
        string nm;
    } exp_t;

    localparam ov_t E_RST = '0;
    localparam ov_t E_FW  = '{st:4'd0, mr:1'b1, asb:2'b01, default:'0};
    localparam ov_t E_FR  = '{st:4'd0, mr:1'b1, asb:2'b01, irw:1'b1, pcw:1'b1, default:'0};
    localparam ov_t E_DEC = '{st:4'd1, asb:2'b11, default:'0};
    localparam ov_t E_MA  = '{st:4'd2, asa:1'b1, asb:2'b10, default:'0};
    localparam ov_t E_MRD = '{st:4'd3, iord:2'b01, mr:1'b1, default:'0};
    localparam ov_t E_MWB = '{st:4'd4, m2r:2'b01, rw:1'b1, default:'0};
    localparam ov_t E_MWR = '{st:4'd5, iord:2'b01, mw:1'b1, default:'0};
    localparam ov_t E_EX  = '{st:4'd6, asa:1'b1, aop:2'b10, default:'0};
    localparam ov_t E_RWB = '{st:4'd7, rd:2'b01, rw:1'b1, default:'0};
    localparam ov_t E_BQT = '{st:4'd8, asa:1'b1, aop:2'b01, psrc:2'b01, pcw:1'b1, default:'0};
    localparam ov_t E_BQN = '{st:4'd8, asa:1'b1, aop:2'b01, psrc:2'b01, default:'0};
    localparam ov_t E_NEX = '{st:4'd9, asa:1'b1, asb:2'b10, aop:2'b11, default:'0};
    localparam ov_t E_NWB = '{st:4'd10, rw:1'b1, default:'0};
    localparam ov_t E_BLT = '{st:4'd11, pcw:1'b1, psrc:2'b01, rw:1'b1, rd:2'b10, m2r:2'b10, default:'0};
    localparam ov_t E_BLN = '{st:4'd11, default:'0};
    localparam ov_t E_BGT = '{st:4'd12, pcw:1'b1, psrc:2'b01, rw:1'b1, rd:2'b10, m2r:2'b10, default:'0};
    localparam ov_t E_BGN = '{st:4'd12, psrc:2'b01, rw:1'b1, rd:2'b10, m2r:2'b10, default:'0};
    localparam ov_t E_JW  = '{st:4'd13, iord:2'b10, mr:1'b1, default:'0};
    localparam ov_t E_JR  = '{st:4'd13, iord:2'b10, mr:1'b1, pcw:1'b1, psrc:2'b10, default:'0};
    localparam ov_t E_HI  = '{st:4'd14, ill:1'b1, default:'0};
    localparam ov_t E_HF  = '{st:4'd14, mf:1'b1, default:'0};

    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_NANDI  = 6'b010000;
    localparam logic [5:0] OP_BALN   = 6'b011011;
    localparam logic [5:0] OP_BGEZAL = 6'b000001;
    localparam logic [5:0] OP_JSP    = 6'b010010;

    logic       clk = 1'b0;
    logic       reset, zero, status_n, rs_sign, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op, mem_fault;
    logic [1:0] iord, reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;
    ov_t        obs;
    exp_t       sb_q[$];
    exp_t       cur;
    int         checks = 0;
    int         errors = 0;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .status_n(status_n),
        .rs_sign(rs_sign), .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal_op(illegal_op), .mem_fault(mem_fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, mem_fault};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            checks++;
            if (obs !== cur.v) begin
                errors++;
                $display("FAIL %s: got %h want %h", cur.nm, obs, cur.v);
            end
        end
    end

    task automatic expect_now(input ov_t e, input string nm);
        exp_t x;
        x.v  = e;
        x.nm = nm;
        sb_q.push_back(x);
    endtask

    task automatic cyc(input logic mr, input ov_t e, input string nm);
        mem_ready = mr;
        expect_now(e, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [5:0] op, input int waits);
        opcode = op;
        for (int i = 0; i < waits; i++) cyc(1'b0, E_FW, "fetch_wait");
        cyc(1'b1, E_FR, "fetch_done");
    endtask

    task automatic pulse_reset(input string nm);
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        expect_now(E_RST, nm);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0; status_n = 1'b0; rs_sign = 1'b0; mem_ready = 1'b0; opcode = OP_R;
        expect_now(E_RST, "reset_state");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // lw with three stall cycles on both accesses
        do_fetch(OP_LW, 3);
        cyc(1'b0, E_DEC, "lw_decode");
        cyc(1'b0, E_MA, "lw_memaddr");
        for (int i = 0; i < 3; i++) cyc(1'b0, E_MRD, "lw_memread_wait");
        cyc(1'b1, E_MRD, "lw_memread_done");
        cyc(1'b0, E_MWB, "lw_memwb");

        do_fetch(OP_SW, 0);
        cyc(1'b0, E_DEC, "sw_decode");
        cyc(1'b0, E_MA, "sw_memaddr");
        cyc(1'b1, E_MWR, "sw_memwrite");

        do_fetch(OP_R, 0);
        cyc(1'b0, E_DEC, "r_decode");
        cyc(1'b0, E_EX, "r_exec");
        cyc(1'b0, E_RWB, "r_wb");

        do_fetch(OP_BEQ, 0);
        cyc(1'b0, E_DEC, "beq_decode");
        zero = 1'b1;
        cyc(1'b0, E_BQT, "beq_taken");
        zero = 1'b0;
        do_fetch(OP_BEQ, 0);
        cyc(1'b0, E_DEC, "beq_decode");
        cyc(1'b0, E_BQN, "beq_not_taken");

        do_fetch(OP_NANDI, 0);
        cyc(1'b0, E_DEC, "nandi_decode");
        cyc(1'b0, E_NEX, "nandi_ex");
        cyc(1'b0, E_NWB, "nandi_wb");

        status_n = 1'b1;
        do_fetch(OP_BALN, 0);
        cyc(1'b0, E_DEC, "baln_decode");
        cyc(1'b0, E_BLT, "baln_taken");
        status_n = 1'b0;
        do_fetch(OP_BALN, 0);
        cyc(1'b0, E_DEC, "baln_decode");
        cyc(1'b0, E_BLN, "baln_not_taken");

        rs_sign = 1'b0;
        do_fetch(OP_BGEZAL, 0);
        cyc(1'b0, E_DEC, "bgezal_decode");
        cyc(1'b0, E_BGT, "bgezal_taken");
        rs_sign = 1'b1;
        do_fetch(OP_BGEZAL, 0);
        cyc(1'b0, E_DEC, "bgezal_decode");
        cyc(1'b0, E_BGN, "bgezal_link_only");
        rs_sign = 1'b0;

        do_fetch(OP_JSP, 0);
        cyc(1'b0, E_DEC, "jsp_decode");
        cyc(1'b0, E_JW, "jsp_wait1");
        cyc(1'b0, E_JW, "jsp_wait2");
        cyc(1'b1, E_JR, "jsp_done");

        // mem_ready arriving on the last permitted cycle beats the watchdog; counter clears per state
        do_fetch(OP_LW, 15);
        cyc(1'b0, E_DEC, "edge_decode");
        cyc(1'b0, E_MA, "edge_memaddr");
        for (int i = 0; i < 15; i++) cyc(1'b0, E_MRD, "edge_memread_wait");
        cyc(1'b1, E_MRD, "edge_memread_done");
        cyc(1'b0, E_MWB, "edge_memwb");

        do_fetch(OP_LW, 0);
        cyc(1'b0, E_DEC, "abort_decode");
        cyc(1'b0, E_MA, "abort_memaddr");
        cyc(1'b0, E_MRD, "abort_memread");
        pulse_reset("reset_mid_memread");
        cyc(1'b0, E_FW, "after_reset_fetch");

        do_fetch(6'b111111, 0);
        cyc(1'b0, E_DEC, "illegal_decode");
        cyc(1'b0, E_HI, "illegal_halt");
        cyc(1'b1, E_HI, "illegal_halt_sticky");

        pulse_reset("reset_clear_illegal");
        for (int i = 0; i < 16; i++) cyc(1'b0, E_FW, "watchdog_wait");
        cyc(1'b0, E_HF, "watchdog_halt");
        cyc(1'b1, E_HF, "watchdog_sticky");
        cyc(1'b0, E_HF, "watchdog_sticky2");

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
